// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing decoder: locks to hSync/vSync, rebuilds pixel coordinates,
// strobes active pixels and keeps a per-frame checksum plus sync-error pulses.
//
// state  | meaning
// SEARCH | waiting for a vSync assert edge, timing checks ignored
// VERIFY | counting consecutive good frames toward lock
// LOCKED | timing trusted, pixels and checksum emitted
module vga_sync_decoder #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_POL    = 1'b0,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixEn,
  input  logic        hSync,
  input  logic        vSync,
  input  logic [11:0] rgb,
  output logic        pixValid,
  output logic [9:0]  pixX,
  output logic [8:0]  pixY,
  output logic [11:0] pixData,
  output logic        frameStart,
  output logic        locked,
  output logic        syncErr,
  output logic [31:0] frameSum,
  output logic        frameSumValid
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LO    = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_HI    = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_LO    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_HI    = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [9:0] CNT_MAX = 10'h3ff;
  localparam logic [7:0] LOCK_C  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [7:0]  good_cnt, good_nxt;
  logic        h_prev, v_prev, h_as, v_as, h_edge, v_edge;
  logic [9:0]  h_cnt, v_cnt, h_cnt_nxt, v_cnt_nxt;
  logic        line_bad, frame_bad, timing_err;
  logic [31:0] acc;
  logic        full_frame;
  logic        in_window, pix_hit, err_pulse, sum_emit, leave_locked;
  logic [9:0]  pix_x_nxt;
  logic [8:0]  pix_y_nxt;

  assign h_as   = (hSync == SYNC_POL);
  assign v_as   = (vSync == SYNC_POL);
  assign h_edge = pixEn && h_as && !h_prev;
  assign v_edge = pixEn && v_as && !v_prev;
  assign locked = (state == LOCKED);

  // Raster measurement on the current sample; edges are already gated by pixEn.
  always_comb begin
    h_cnt_nxt = (h_cnt == CNT_MAX) ? h_cnt : h_cnt + 10'd1;
    if (h_edge) h_cnt_nxt = '0;
    v_cnt_nxt = v_cnt;
    if (v_edge) v_cnt_nxt = '0;
    else if (h_edge && v_cnt != CNT_MAX) v_cnt_nxt = v_cnt + 10'd1;
    line_bad   = h_edge && (h_cnt != H_LAST);
    frame_bad  = v_edge && (v_cnt != V_LAST);
    timing_err = pixEn && (line_bad || frame_bad || h_cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      SEARCH: if (v_edge) begin
        state_nxt = VERIFY;
        good_nxt  = '0;
      end
      VERIFY: begin
        if (timing_err) state_nxt = SEARCH;
        else if (v_edge) begin
          good_nxt = good_cnt + 8'd1;
          if (good_cnt + 8'd1 == LOCK_C) state_nxt = LOCKED;
        end
      end
      LOCKED: if (timing_err) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // A frame counts as fully locked when it starts on an edge that leaves the FSM in LOCKED.
  always_comb begin
    in_window    = (h_cnt_nxt >= H_LO) && (h_cnt_nxt < H_HI) &&
                   (v_cnt_nxt >= V_LO) && (v_cnt_nxt < V_HI);
    pix_hit      = pixEn && (state_nxt == LOCKED) && in_window;
    err_pulse    = timing_err && (state != SEARCH);
    sum_emit     = v_edge && (state == LOCKED) && full_frame;
    leave_locked = (state == LOCKED) && (state_nxt != LOCKED);
    pix_x_nxt    = h_cnt_nxt - H_LO;
    pix_y_nxt    = 9'(v_cnt_nxt - V_LO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_prev        <= 1'b0;
      v_prev        <= 1'b0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      acc           <= '0;
      full_frame    <= 1'b0;
      pixValid      <= 1'b0;
      pixX          <= '0;
      pixY          <= '0;
      pixData       <= '0;
      frameStart    <= 1'b0;
      syncErr       <= 1'b0;
      frameSum      <= '0;
      frameSumValid <= 1'b0;
    end else begin
      pixValid      <= 1'b0;
      frameStart    <= 1'b0;
      syncErr       <= 1'b0;
      frameSumValid <= 1'b0;
      if (pixEn) begin
        h_prev     <= h_as;
        v_prev     <= v_as;
        h_cnt      <= h_cnt_nxt;
        v_cnt      <= v_cnt_nxt;
        pixValid   <= pix_hit;
        frameStart <= v_edge;
        syncErr    <= err_pulse;
        if (pix_hit) begin
          pixX    <= pix_x_nxt;
          pixY    <= pix_y_nxt;
          pixData <= rgb;
        end
        if (sum_emit) begin
          frameSum      <= acc;
          frameSumValid <= 1'b1;
        end
        if (leave_locked || v_edge) acc <= '0;
        else if (pix_hit) acc <= acc + {20'd0, rgb};
        if (v_edge) full_frame <= (state_nxt == LOCKED);
        else if (state_nxt != LOCKED) full_frame <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Randomized bench for vga_sync_decoder on a shrunken raster: a per-sample reference
// model queues expected outputs, a monitor pops and compares after each sampled clk.
module tb_vga_sync_decoder;

  localparam int   H_ACTIVE = 8,  H_FRONT = 2, H_SYNC = 3, H_BACK = 2;
  localparam int   V_ACTIVE = 6,  V_FRONT = 1, V_SYNC = 2, V_BACK = 2;
  localparam logic SYNC_POL = 1'b0;
  localparam int   LOCK_FRAMES = 2;
  localparam int   H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int   V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int   H_OFF = H_SYNC + H_BACK;
  localparam int   V_OFF = V_SYNC + V_BACK;

  logic        clk, reset, pixEn, hSync, vSync;
  logic [11:0] rgb;
  logic        pixValid, frameStart, locked, syncErr, frameSumValid;
  logic [9:0]  pixX;
  logic [8:0]  pixY;
  logic [11:0] pixData;
  logic [31:0] frameSum;

  vga_sync_decoder #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .SYNC_POL(SYNC_POL), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .pixEn(pixEn), .hSync(hSync), .vSync(vSync), .rgb(rgb),
    .pixValid(pixValid), .pixX(pixX), .pixY(pixY), .pixData(pixData),
    .frameStart(frameStart), .locked(locked), .syncErr(syncErr),
    .frameSum(frameSum), .frameSumValid(frameSumValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pv;
    int          x;
    int          y;
    logic [11:0] d;
    bit          fs;
    bit          lk;
    bit          se;
    bit          fsv;
    logic [31:0] sum;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: sync history, position within line/frame, lock progress, frame sum.
  bit          m_hp, m_vp, m_full;
  int          m_pos, m_line, m_good, m_mode;   // m_mode: 0 hunting, 1 qualifying, 2 locked
  logic [31:0] m_acc;

  function automatic void m_reset();
    m_hp = 0; m_vp = 0; m_full = 0;
    m_pos = 0; m_line = 0; m_good = 0; m_mode = 0;
    m_acc = '0;
  endfunction

  function automatic void m_step(input bit h, input bit v, input logic [11:0] c);
    exp_t e;
    bit   he, ve, bad;
    int   pos_n, line_n, mode_n;
    e = '{default: 0};
    he = h && !m_hp;
    ve = v && !m_vp;
    bad = (he && m_pos + 1 != H_TOTAL) || (ve && m_line + 1 != V_TOTAL);
    pos_n  = he ? 0 : ((m_pos + 1 > 1023) ? 1023 : m_pos + 1);
    line_n = ve ? 0 : (he ? ((m_line + 1 > 1023) ? 1023 : m_line + 1) : m_line);
    if (pos_n == 1023) bad = 1;
    mode_n = m_mode;
    if (m_mode == 0) begin
      if (ve) begin mode_n = 1; m_good = 0; end
    end else if (bad) begin
      mode_n = 0;
      e.se = 1;
    end else if (m_mode == 1 && ve) begin
      m_good++;
      if (m_good == LOCK_FRAMES) mode_n = 2;
    end
    e.fs = ve;
    e.lk = (mode_n == 2);
    e.pv = e.lk && pos_n >= H_OFF && pos_n < H_OFF + H_ACTIVE &&
           line_n >= V_OFF && line_n < V_OFF + V_ACTIVE;
    e.x = pos_n - H_OFF;
    e.y = line_n - V_OFF;
    e.d = c;
    if (ve && m_mode == 2 && m_full) begin e.fsv = 1; e.sum = m_acc; end
    if ((m_mode == 2 && mode_n != 2) || ve) m_acc = '0;
    else if (e.pv) m_acc = m_acc + 32'(c);
    if (ve) m_full = (mode_n == 2);
    else if (mode_n != 2) m_full = 0;
    m_hp = h; m_vp = v; m_pos = pos_n; m_line = line_n; m_mode = mode_n;
    q.push_back(e);
  endfunction

  // Monitor statistics from the DUT side for the directed frame checks.
  int err_cnt = 0, cur_pix = 0, first_x = -1, first_y = -1, last_x = -1, last_y = -1;
  bit got_first = 0;
  logic [31:0] last_fsum = '0;

  always @(posedge clk) begin
    bit   smp;
    exp_t e;
    smp = pixEn && reset;
    #1;
    if (smp) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL queue_underrun: got sample with no expected entry at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("locked", 64'(locked), 64'(e.lk));
        chk("frameStart", 64'(frameStart), 64'(e.fs));
        chk("syncErr", 64'(syncErr), 64'(e.se));
        chk("pixValid", 64'(pixValid), 64'(e.pv));
        chk("frameSumValid", 64'(frameSumValid), 64'(e.fsv));
        if (e.pv && pixValid) begin
          chk("pixX", 64'(pixX), 64'(e.x));
          chk("pixY", 64'(pixY), 64'(e.y));
          chk("pixData", 64'(pixData), 64'(e.d));
        end
        if (e.fsv && frameSumValid) chk("frameSum", 64'(frameSum), 64'(e.sum));
      end
    end else begin
      chk("pulse_idle", 64'({pixValid, frameStart, syncErr, frameSumValid}), 64'(0));
    end
    if (syncErr) err_cnt++;
    if (frameSumValid) last_fsum = frameSum;
    if (frameStart) begin cur_pix = 0; got_first = 0; end
    if (pixValid) begin
      cur_pix++;
      if (!got_first) begin first_x = int'(pixX); first_y = int'(pixY); got_first = 1; end
      last_x = int'(pixX);
      last_y = int'(pixY);
    end
  end

  task automatic apply(input bit h_as, input bit v_as, input logic [11:0] c);
    int gap;
    gap = $urandom_range(3, 0);
    repeat (gap) begin @(posedge clk); #2; pixEn = 1'b0; end
    @(posedge clk); #2;
    pixEn = 1'b1;
    hSync = h_as ? SYNC_POL : ~SYNC_POL;
    vSync = v_as ? SYNC_POL : ~SYNC_POL;
    rgb   = c;
    m_step(h_as, v_as, c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; pixEn = 1'b0; end
  endtask

  // mode 0 random colour, 1 constant 12'h00F, 2 coordinate pattern
  task automatic run_frame(input int mode, input int short_ln, input int l0, input int l1);
    for (int v = l0; v <= l1; v++) begin
      int len;
      len = (v == short_ln) ? H_TOTAL - 1 : H_TOTAL;
      for (int h = 0; h < len; h++) begin
        logic [11:0] c;
        logic [9:0]  xv, yv;
        xv = 10'(h - H_OFF);
        yv = 10'(v - V_OFF);
        case (mode)
          0:       c = 12'($urandom);
          1:       c = 12'h00F;
          default: c = {xv[3:0], yv[3:0], 4'h0};
        endcase
        apply(h < H_SYNC, v < V_SYNC, c);
      end
    end
  endtask

  task automatic frames(input int mode, input int n);
    repeat (n) run_frame(mode, -1, 0, V_TOTAL - 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; pixEn = 1'b0; hSync = ~SYNC_POL; vSync = ~SYNC_POL; rgb = '0;
    m_reset();
    #1;
    chk("reset_outputs", 64'({pixValid, pixX, pixY, pixData, frameStart, locked, syncErr, frameSumValid}), 64'(0));
    chk("reset_frameSum", 64'(frameSum), 64'(0));
    idle(3);
    reset = 1'b1;

    // Ideal timing from reset: lock after the third vSync edge, no errors.
    frames(0, 4);
    idle(2);
    chk("locked_after_ideal", 64'(locked), 64'(1));
    chk("no_err_ideal", 64'(err_cnt), 64'(0));

    // Constant frame checksum, then coordinate pattern frame.
    frames(1, 1);
    frames(2, 1);
    idle(2);
    chk("const_frame_sum", 64'(last_fsum), 64'(H_ACTIVE * V_ACTIVE * 15));
    chk("pix_per_frame", 64'(cur_pix), 64'(H_ACTIVE * V_ACTIVE));
    chk("first_pix_xy", 64'({first_x[15:0], first_y[15:0]}), 64'({16'd0, 16'd0}));
    chk("last_pix_xy", 64'({last_x[15:0], last_y[15:0]}), 64'({16'(H_ACTIVE - 1), 16'(V_ACTIVE - 1)}));

    // One short line while locked, then relock.
    run_frame(0, V_OFF + 2, 0, V_TOTAL - 1);
    idle(2);
    chk("locked_after_short", 64'(locked), 64'(0));
    chk("err_after_short", 64'(err_cnt), 64'(1));
    frames(0, 3);
    idle(2);
    chk("relocked", 64'(locked), 64'(1));

    // hSync stuck deasserted: hCount saturates and drops lock.
    for (int i = 0; i < 1100; i++) apply(1'b0, 1'b0, 12'($urandom));
    idle(2);
    chk("locked_after_stuck", 64'(locked), 64'(0));
    chk("err_after_stuck", 64'(err_cnt), 64'(2));

    // Relock, then reset mid-frame.
    frames(0, 3);
    run_frame(0, -1, 0, 4);
    @(posedge clk); #2; pixEn = 1'b0;
    #1; reset = 1'b0;
    #1;
    chk("midreset_outputs", 64'({pixValid, pixX, pixY, pixData, frameStart, locked, syncErr, frameSumValid}), 64'(0));
    chk("midreset_frameSum", 64'(frameSum), 64'(0));
    m_reset();
    q.delete();
    repeat (3) @(posedge clk);
    #2; reset = 1'b1;
    run_frame(0, -1, 5, V_TOTAL - 1);
    frames(0, 2);
    idle(2);
    chk("not_locked_two_edges", 64'(locked), 64'(0));
    frames(0, 1);
    idle(2);
    chk("locked_third_edge", 64'(locked), 64'(1));

    idle(4);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive end of the VGA video interface: samples hSync, vSync and 12-bit RGB as produced by the display pipeline's timing generator and colour path.
- Locks onto the raster timing, reconstructs pixel coordinates, and emits per-pixel data with a valid strobe.
- Produces a per-frame pixel checksum and sync-error flags, for in-system capture and self-check of the video output path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hSync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vSync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to lock

Ports:
- clk  in  1  100 MHz system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- pixEn  in  1  pixel-rate sample enable, one clk every 4
- hSync  in  1  horizontal sync, synchronous to clk
- vSync  in  1  vertical sync, synchronous to clk
- rgb  in  12  {R,G,B} 4 bits each
- pixValid  out  1  pixX/pixY/pixData valid this cycle
- pixX  out  10  active-area column 0..H_ACTIVE-1
- pixY  out  9  active-area row 0..V_ACTIVE-1
- pixData  out  12  sampled rgb
- frameStart  out  1  1-clk pulse on every vSync assert edge
- locked  out  1  timing locked
- syncErr  out  1  1-clk pulse on any timing mismatch while VERIFY/LOCKED
- frameSum  out  32  checksum of the last complete locked frame
- frameSumValid  out  1  1-clk pulse when frameSum updates

Behaviour:
- Derived values: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; H_OFF = H_SYNC+H_BACK; V_OFF = V_SYNC+V_BACK.
- Sampling: all inputs are sampled only on clk cycles where pixEn=1. Outputs are registered and change on the clk after the sampling cycle, so latency is 1 clk. Outputs are not updated when pixEn=0.
- Pulse outputs: pixValid, frameStart, syncErr and frameSumValid are high for exactly one clk.
- Edge detection: an assert edge occurs when the previous sample was deasserted and the current sample is asserted (asserted means level == SYNC_POL).
- hCount (10 bit):
  - set to 0 on an hSync assert edge;
  - otherwise incremented each sample, saturating at 1023.
- Line length: the measured length is hCount+1 at the hSync edge. A line is good when this equals H_TOTAL.
- vCount (10 bit):
  - set to 0 on a vSync assert edge; this takes priority over a same-sample hSync edge;
  - otherwise incremented on each hSync assert edge, saturating at 1023.
- Frame length: the measured length is vCount+1 at the vSync edge. A frame is good when this equals V_TOTAL and no bad line occurred since the previous vSync edge.
- FSM states and transitions:
  - SEARCH (reset state). The first vSync assert edge moves to VERIFY with goodCnt=0. Line and frame checks are ignored in SEARCH.
  - VERIFY. A good frame increments goodCnt; at goodCnt == LOCK_FRAMES the FSM moves to LOCKED. A bad line, a bad frame, or hCount reaching 1023 moves to SEARCH and pulses syncErr.
  - LOCKED. The same error conditions move to SEARCH, pulse syncErr and drop locked on the same clk.
- locked = 1 only in LOCKED.
- pixValid = locked AND H_OFF ≤ hCount < H_OFF+H_ACTIVE AND V_OFF ≤ vCount < V_OFF+V_ACTIVE, evaluated on the post-update counts.
- When pixValid=1: pixX = hCount−H_OFF, pixY = vCount−V_OFF, pixData = rgb from the same sample.
- Checksum:
  - acc (32 bit) adds zero-extended pixData for each pixValid, wrapping mod 2^32.
  - On a vSync assert edge in LOCKED (before any error evaluation changes state): frameSum ← acc and frameSumValid pulses, but only if the FSM was LOCKED for the entire previous frame. acc is then cleared.
  - Leaving LOCKED clears acc.
- Reset: asynchronous, active-low. On assertion (reset low) the FSM goes to SEARCH and hCount, vCount, acc, goodCnt and all outputs go to 0, including frameSum. Previous-sample sync registers are set to the deasserted level. Reset mid-frame requires a full relock.
- Simultaneous hSync and vSync edges in one sample: both checks are evaluated; vCount is set to 0.

Test Plan:
- Ideal 640x480@60 timing, default parameters, from reset → locked rises 1 clk after the 3rd vSync assert edge; syncErr never pulses.
- Locked, rgb held at 12'h00F for a full frame → frameSumValid at the next vSync edge with frameSum = 32'h00465000 (307200×15). pixValid count per frame = 307200.
- Locked, rgb = {pixX[3:0], pixY[3:0], 4'h0} → first pixValid per frame has pixX=0, pixY=0; last has pixX=639, pixY=479; values match the sampled rgb.
- Locked, one line shortened to 799 pixels → syncErr pulse and locked=0 on the clk after that hSync edge; relock after 3 further vSync edges.
- Locked, hSync held deasserted → syncErr and locked=0 when hCount reaches 1023.
- Reset driven low mid-frame for 3 clk → all outputs 0 immediately (asynchronous); after release, locked stays 0 until the 3rd vSync edge.
